// File: rtl/qmca_pulse_extractor.sv
// Pulse-height extractor: arms below threshold, triggers on each rising crossing,
// measures peak and time-over-threshold, and queues one event word per pulse.
module qmca_pulse_extractor #(
  parameter int          ADC_BITS   = 14,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [3:0]  HEADER_ID  = 4'h1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ENABLE,
  input  logic [ADC_BITS-1:0] ADC_IN,
  input  logic [ADC_BITS-1:0] THRESHOLD,
  input  logic [ADC_BITS-1:0] BASELINE,
  output logic                TRIGGER,
  output logic                BUSY,
  input  logic                FIFO_READ,
  output logic                FIFO_EMPTY,
  output logic [31:0]         FIFO_DATA,
  output logic [7:0]          LOST_COUNT
);

  localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [ADC_BITS-1:0] TOT_MAX   = '1;
  localparam logic [ADC_BITS-1:0] TOT_ONE   = ADC_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_DEPTH = CNT_BITS'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    PULSE,
    WRITE
  } state_t;

  state_t state;
  state_t state_next;

  logic [ADC_BITS-1:0] adc_q;
  logic [ADC_BITS-1:0] peak;
  logic [ADC_BITS-1:0] tot;
  logic [ADC_BITS-1:0] amp;
  logic                above;
  logic                trigger_next;
  logic                busy_next;
  logic                start_pulse;
  logic                track_pulse;
  logic                push;
  logic [31:0]         event_word;

  logic [31:0]         mem [FIFO_DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS-1:0] rd_ptr_next;
  logic [CNT_BITS-1:0] count;
  logic [CNT_BITS-1:0] count_after_pop;
  logic [CNT_BITS-1:0] count_next;
  logic                pop;
  logic                push_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      adc_q <= '0;
    end else begin
      adc_q <= ADC_IN;
    end
  end

  assign above = (adc_q > THRESHOLD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      TRIGGER <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_next;
      TRIGGER <= trigger_next;
      BUSY    <= busy_next;
    end
  end

  // Dropping ENABLE always wins, so a partially measured pulse is never queued.
  always_comb begin
    state_next   = state;
    trigger_next = 1'b0;
    start_pulse  = 1'b0;
    track_pulse  = 1'b0;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (ENABLE && !above) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (!ENABLE) begin
          state_next = IDLE;
        end else if (above) begin
          state_next   = PULSE;
          trigger_next = 1'b1;
          start_pulse  = 1'b1;
        end
      end
      PULSE: begin
        if (!ENABLE) begin
          state_next = IDLE;
        end else if (above) begin
          track_pulse = 1'b1;
        end else begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        push       = 1'b1;
        state_next = ENABLE ? ARMED : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    busy_next = (state_next == PULSE) || (state_next == WRITE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      peak <= '0;
      tot  <= '0;
    end else if (start_pulse) begin
      peak <= adc_q;
      tot  <= TOT_ONE;
    end else if (track_pulse) begin
      if (adc_q > peak) begin
        peak <= adc_q;
      end
      if (tot != TOT_MAX) begin
        tot <= tot + TOT_ONE;
      end
    end
  end

  assign amp        = (peak >= BASELINE) ? (peak - BASELINE) : '0;
  assign event_word = {HEADER_ID, 14'(amp), 14'(tot)};

  // A pop in the WRITE cycle frees a slot, so a full FIFO can still take the word.
  assign pop             = FIFO_READ && (count != '0);
  assign push_ok         = push && ((count < CNT_DEPTH) || pop);
  assign count_after_pop = count - CNT_BITS'(pop);
  assign count_next      = count_after_pop + CNT_BITS'(push_ok);
  assign rd_ptr_next     = rd_ptr + PTR_BITS'(pop);

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= event_word;
    end
  end

  // The head register is refilled from storage, or straight from the new word
  // when it lands in an otherwise empty FIFO.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      FIFO_EMPTY <= 1'b1;
      FIFO_DATA  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      rd_ptr     <= rd_ptr_next;
      count      <= count_next;
      FIFO_EMPTY <= (count_next == '0);
      if (count_after_pop == '0) begin
        if (push_ok) begin
          FIFO_DATA <= event_word;
        end
      end else begin
        FIFO_DATA <= mem[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      LOST_COUNT <= '0;
    end else if (push && !push_ok && (LOST_COUNT != 8'hFF)) begin
      LOST_COUNT <= LOST_COUNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_qmca_pulse_extractor.sv
// Bench for qmca_pulse_extractor: pulse-level reference model feeding a word
// scoreboard, with a monitor that checks every word popped from the FIFO.
module tb_qmca_pulse_extractor;

  localparam int DEPTH   = 16;
  localparam int TOT_SAT = 16383;

  logic        CLK;
  logic        RST;
  logic        ENABLE;
  logic [13:0] ADC_IN;
  logic [13:0] THRESHOLD;
  logic [13:0] BASELINE;
  logic        TRIGGER;
  logic        BUSY;
  logic        FIFO_READ;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic [7:0]  LOST_COUNT;

  qmca_pulse_extractor #(
    .ADC_BITS  (14),
    .FIFO_DEPTH(DEPTH),
    .HEADER_ID (4'h1)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENABLE    (ENABLE),
    .ADC_IN    (ADC_IN),
    .THRESHOLD (THRESHOLD),
    .BASELINE  (BASELINE),
    .TRIGGER   (TRIGGER),
    .BUSY      (BUSY),
    .FIFO_READ (FIFO_READ),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA (FIFO_DATA),
    .LOST_COUNT(LOST_COUNT)
  );

  logic [31:0] exp_q[$];
  int          checks_total  = 0;
  int          checks_passed = 0;
  int          exp_trig      = 0;
  int          trig_seen     = 0;
  int          reads_done    = 0;
  int          lost_exp      = 0;
  int          th            = 1000;
  int          bl            = 200;
  bit          force_read    = 1'b0;
  bit          rand_rd       = 1'b0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Event word from pulse-level quantities: height above baseline and duration.
  function automatic logic [31:0] model_word(int pk, int t, int b);
    int a;
    int tt;
    a  = (pk >= b) ? pk - b : 0;
    tt = (t > TOT_SAT) ? TOT_SAT : t;
    return {4'h1, 14'(a), 14'(tt)};
  endfunction

  initial begin
    FIFO_READ = 1'b0;
    forever begin
      @(posedge CLK);
      #2;
      FIFO_READ = force_read || (rand_rd && ($urandom_range(1, 0) == 1));
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (TRIGGER) trig_seen++;
      if (FIFO_READ && !FIFO_EMPTY) begin
        reads_done++;
        if (exp_q.size() == 0) begin
          checks_total++;
          $display("[TB] FAIL fifo_unexpected: got word 0x%0h, expected no word", FIFO_DATA);
        end else begin
          check_output("fifo_word", FIFO_DATA, exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(int v);
    ADC_IN = 14'(v);
    tick();
  endtask

  function automatic int below_sample();
    if ($urandom_range(7, 0) == 0) return th;
    return int'($urandom_range(th, 0));
  endfunction

  task automatic set_levels(int t, int b);
    th        = t;
    bl        = b;
    THRESHOLD = 14'(t);
    BASELINE  = 14'(b);
  endtask

  // One complete pulse: quiet gap, n_above samples over threshold, quiet tail.
  task automatic send_pulse(int n_above, int lo, int hi, int gap, bit read_at_write);
    int pk;
    int v;
    for (int i = 0; i < gap; i++) apply_stimulus(below_sample());
    pk = 0;
    for (int i = 0; i < n_above; i++) begin
      v = int'($urandom_range(hi, lo));
      if (v > pk) pk = v;
      apply_stimulus(v);
    end
    exp_trig++;
    if ((exp_q.size() < DEPTH) || read_at_write) begin
      exp_q.push_back(model_word(pk, n_above, bl));
    end else if (lost_exp < 255) begin
      lost_exp++;
    end
    apply_stimulus(below_sample());
    apply_stimulus(below_sample());
    if (read_at_write) force_read = 1'b1;
    apply_stimulus(below_sample());
    force_read = 1'b0;
  endtask

  task automatic drain_fifo(output int n_read);
    int start;
    start = reads_done;
    for (int i = 0; i < 64; i++) begin
      if (FIFO_EMPTY) break;
      force_read = 1'b1;
      tick();
    end
    force_read = 1'b0;
    tick();
    n_read = reads_done - start;
    check_output("drain_empty", 32'(FIFO_EMPTY), 32'd1);
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    ADC_IN = '0;
    tick();
    tick();
    exp_q.delete();
    lost_exp = 0;
    RST      = 1'b0;
  endtask

  initial begin
    int n;
    RST    = 1'b1;
    ENABLE = 1'b0;
    ADC_IN = '0;
    set_levels(1000, 200);
    tick();
    tick();
    check_output("rst_trigger", 32'(TRIGGER), 32'd0);
    check_output("rst_busy", 32'(BUSY), 32'd0);
    check_output("rst_empty", 32'(FIFO_EMPTY), 32'd1);
    check_output("rst_data", FIFO_DATA, 32'd0);
    check_output("rst_lost", 32'(LOST_COUNT), 32'd0);

    ENABLE = 1'b1;
    do_reset();
    apply_stimulus(100);
    apply_stimulus(1500);
    check_output("trig_early", 32'(TRIGGER), 32'd0);
    apply_stimulus(3000);
    check_output("trig_latency", 32'(TRIGGER), 32'd1);
    apply_stimulus(2000);
    check_output("trig_one_cycle", 32'(TRIGGER), 32'd0);
    exp_q.push_back(32'h12BC_0003);
    exp_trig++;
    apply_stimulus(900);
    apply_stimulus(100);
    check_output("write_busy", 32'(BUSY), 32'd1);
    check_output("write_empty", 32'(FIFO_EMPTY), 32'd1);
    apply_stimulus(100);
    check_output("push_empty", 32'(FIFO_EMPTY), 32'd0);
    check_output("push_busy", 32'(BUSY), 32'd0);
    drain_fifo(n);
    check_output("basic_count", 32'(n), 32'd1);

    ENABLE = 1'b0;
    apply_stimulus(1500);
    apply_stimulus(1500);
    ENABLE = 1'b1;
    for (int i = 0; i < 5; i++) apply_stimulus(1500);
    check_output("enable_high_trig", 32'(trig_seen), 32'(exp_trig));
    check_output("enable_high_empty", 32'(FIFO_EMPTY), 32'd1);
    send_pulse(3, 1500, 1500, 2, 1'b0);
    check_output("rearm_trig", 32'(trig_seen), 32'(exp_trig));

    set_levels(1000, 3000);
    send_pulse(3, 2000, 2000, 3, 1'b0);
    send_pulse(20000, 5000, 5000, 3, 1'b0);
    drain_fifo(n);
    check_output("amp_tot_count", 32'(n), 32'd3);

    set_levels(1000, 200);
    for (int i = 0; i < 20; i++) send_pulse($urandom_range(6, 1), 1001, 16383, 2, 1'b0);
    check_output("overflow_lost", 32'(LOST_COUNT), 32'(lost_exp));
    drain_fifo(n);
    check_output("overflow_kept", 32'(n), 32'(DEPTH));
    force_read = 1'b1;
    tick();
    force_read = 1'b0;
    tick();
    tick();
    check_output("empty_read_noop", 32'(FIFO_EMPTY), 32'd1);
    check_output("empty_read_lost", 32'(LOST_COUNT), 32'(lost_exp));

    for (int i = 0; i < DEPTH; i++) send_pulse($urandom_range(6, 1), 1001, 16383, 2, 1'b0);
    send_pulse(4, 1001, 16383, 2, 1'b1);
    check_output("full_pop_lost", 32'(LOST_COUNT), 32'(lost_exp));
    drain_fifo(n);
    check_output("full_pop_count", 32'(n), 32'(DEPTH));

    for (int i = 0; i < 3; i++) apply_stimulus(below_sample());
    apply_stimulus(4000);
    apply_stimulus(4000);
    apply_stimulus(4000);
    exp_trig++;
    ENABLE = 1'b0;
    apply_stimulus(4000);
    check_output("abort_busy", 32'(BUSY), 32'd0);
    check_output("abort_trigger", 32'(TRIGGER), 32'd0);
    ENABLE = 1'b1;
    for (int i = 0; i < 4; i++) apply_stimulus(below_sample());
    check_output("abort_no_word", 32'(FIFO_EMPTY), 32'd1);

    send_pulse(2, 1500, 3000, 2, 1'b0);
    send_pulse(2, 1500, 3000, 2, 1'b0);
    for (int i = 0; i < 2; i++) apply_stimulus(below_sample());
    apply_stimulus(4000);
    apply_stimulus(4000);
    apply_stimulus(4000);
    exp_trig++;
    RST = 1'b1;
    apply_stimulus(4000);
    exp_q.delete();
    lost_exp = 0;
    check_output("rst_mid_busy", 32'(BUSY), 32'd0);
    check_output("rst_mid_trigger", 32'(TRIGGER), 32'd0);
    check_output("rst_mid_empty", 32'(FIFO_EMPTY), 32'd1);
    check_output("rst_mid_lost", 32'(LOST_COUNT), 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(0);
    check_output("rst_mid_no_word", 32'(FIFO_EMPTY), 32'd1);

    rand_rd = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 3; i++) apply_stimulus(0);
      set_levels(int'($urandom_range(12000, 500)), int'($urandom_range(14000, 0)));
      for (int p = 0; p < 25; p++) begin
        for (int g = 0; (g < 200) && (exp_q.size() >= 12); g++) apply_stimulus(below_sample());
        if ($urandom_range(7, 0) == 0) begin
          send_pulse($urandom_range(8, 1), th + 1, th + 1, $urandom_range(5, 2), 1'b0);
        end else begin
          send_pulse($urandom_range(8, 1), th + 1, 16383, $urandom_range(5, 2), 1'b0);
        end
      end
    end
    rand_rd = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(0);
    drain_fifo(n);
    check_output("final_exp_left", 32'(exp_q.size()), 32'd0);
    check_output("final_triggers", 32'(trig_seen), 32'(exp_trig));
    check_output("final_lost", 32'(LOST_COUNT), 32'(lost_exp));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
